// File: rtl/fm_pingpong_ctrl.sv
// rtl/fm_pingpong_ctrl.sv - two-buffer ping-pong controller for the fragment memory
// Steers the base stream into the filling buffer and hands closed buffers to the reader in fill order.
module fm_pingpong_ctrl #(
  parameter int BASE_LEN = 2,
  parameter int BUF_SIZE = 16,
  parameter int MIN_LEN  = 4,
  parameter int AW       = 4,
  parameter int LW       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BASE_LEN-1:0] in_base,
  input  logic                in_last,
  output logic                buf_wr_en,
  output logic                buf_wr_sel,
  output logic [AW-1:0]       buf_wr_addr,
  output logic [BASE_LEN-1:0] buf_wr_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rd_sel,
  output logic [LW-1:0]       rd_len,
  output logic                rd_short,
  input  logic                rd_release,
  output logic [1:0]          full_count
);

  typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL, ST_READING} buf_st_e;

  buf_st_e             st_q [2];
  buf_st_e             st_d [2];
  logic [LW-1:0]       len_q [2];
  logic [LW-1:0]       len_d [2];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic                wr_buf_q, wr_buf_d;
  logic                rd_buf_q, rd_buf_d;

  logic                in_ready_q, in_ready_d;
  logic                wr_en_q, wr_en_d;
  logic                wr_sel_q, wr_sel_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [BASE_LEN-1:0] wr_data_q, wr_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_sel_q, rd_sel_d;
  logic [LW-1:0]       rd_len_q, rd_len_d;
  logic                rd_short_q, rd_short_d;
  logic [1:0]          full_count_q, full_count_d;

  logic                accept, closing, take, rel_ok, owned;

  always_comb begin
    st_d         = st_q;
    len_d        = len_q;
    wr_ptr_d     = wr_ptr_q;
    wr_buf_d     = wr_buf_q;
    rd_buf_d     = rd_buf_q;
    wr_sel_d     = wr_sel_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    accept  = in_valid && in_ready_q && !flush;
    closing = accept && ((wr_ptr_q == AW'(BUF_SIZE - 1)) || in_last);
    take    = rd_valid_q && rd_ready && (st_q[rd_buf_q] == ST_FULL);
    rel_ok  = rd_release && (st_q[rd_buf_q] == ST_READING);
    owned   = (st_q[rd_buf_q] == ST_FULL) || (st_q[rd_buf_q] == ST_READING);

    wr_en_d = accept;
    if (accept) begin
      wr_sel_d  = wr_buf_q;
      wr_addr_d = wr_ptr_q;
      wr_data_d = in_base;
      if (closing) begin
        st_d[wr_buf_q]  = ST_FULL;
        len_d[wr_buf_q] = LW'(wr_ptr_q) + LW'(1);
        wr_ptr_d        = '0;
        wr_buf_d        = ~wr_buf_q;
      end else begin
        st_d[wr_buf_q] = ST_FILLING;
        wr_ptr_d       = wr_ptr_q + AW'(1);
      end
    end

    // Writer and reader always touch different buffers, so these never collide.
    if (take) st_d[rd_buf_q] = ST_READING;
    if (rel_ok) begin
      st_d[rd_buf_q] = ST_EMPTY;
      rd_buf_d       = ~rd_buf_q;
    end

    in_ready_d   = (st_d[wr_buf_d] == ST_EMPTY) || (st_d[wr_buf_d] == ST_FILLING);
    rd_valid_d   = (st_q[rd_buf_q] == ST_FULL) && !take;
    rd_sel_d     = rd_buf_q;
    rd_len_d     = owned ? len_q[rd_buf_q] : '0;
    rd_short_d   = owned && (len_q[rd_buf_q] < LW'(MIN_LEN));
    full_count_d = 2'd0;
    for (int i = 0; i < 2; i++) begin
      if ((st_d[i] == ST_FULL) || (st_d[i] == ST_READING)) full_count_d = full_count_d + 2'd1;
    end

    if (flush) begin
      for (int i = 0; i < 2; i++) begin
        st_d[i]  = ST_EMPTY;
        len_d[i] = '0;
      end
      wr_ptr_d     = '0;
      wr_buf_d     = 1'b0;
      rd_buf_d     = 1'b0;
      in_ready_d   = 1'b0;
      wr_en_d      = 1'b0;
      wr_sel_d     = 1'b0;
      wr_addr_d    = '0;
      wr_data_d    = '0;
      rd_valid_d   = 1'b0;
      rd_sel_d     = 1'b0;
      rd_len_d     = '0;
      rd_short_d   = 1'b0;
      full_count_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= ST_EMPTY;
        len_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      wr_buf_q     <= 1'b0;
      rd_buf_q     <= 1'b0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_sel_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_sel_q     <= 1'b0;
      rd_len_q     <= '0;
      rd_short_q   <= 1'b0;
      full_count_q <= 2'd0;
    end else begin
      st_q         <= st_d;
      len_q        <= len_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_buf_q     <= wr_buf_d;
      rd_buf_q     <= rd_buf_d;
      in_ready_q   <= in_ready_d;
      wr_en_q      <= wr_en_d;
      wr_sel_q     <= wr_sel_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_valid_q   <= rd_valid_d;
      rd_sel_q     <= rd_sel_d;
      rd_len_q     <= rd_len_d;
      rd_short_q   <= rd_short_d;
      full_count_q <= full_count_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign buf_wr_en   = wr_en_q;
  assign buf_wr_sel  = wr_sel_q;
  assign buf_wr_addr = wr_addr_q;
  assign buf_wr_data = wr_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_sel      = rd_sel_q;
  assign rd_len      = rd_len_q;
  assign rd_short    = rd_short_q;
  assign full_count  = full_count_q;

endmodule
